romemu_host_link: RTL

Host-side initiator for the ROM emulator's nibble-serial command link. Accepts byte-level requests from the host controller (set address, write byte, read byte, increment, set mode, reset) and drives the link: 3-bit command, link clock, 4-bit data nibble, with serial read-back of one data bit. Sits between the host controller logic and the emulator's command pins.

---
 rtl/romemu_pkg.sv | 95 +++++++++
 rtl/romemu_link_timer.sv | 32 +++
 rtl/romemu_host_link.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/romemu_pkg.sv
// Shared definitions for the ROM emulator host link: command codes,
// per-command edge counts, FSM states and burst-shaping helpers.
package romemu_pkg;

    // Link command codes as seen on the emulator's command pins.
    typedef enum logic [2:0] {
        CMD_RESET    = 3'd0,
        CMD_SET_ADDR = 3'd1,
        CMD_INC_ADDR = 3'd2,
        CMD_SET_DATA = 3'd3,
        CMD_GET_DATA = 3'd4,
        CMD_SET_MODE = 3'd5,
        CMD_NOP      = 3'd6
    } cmd_e;

    // Link edges per command. The emulator's nibble counters depend on these
    // exact counts, so a burst is never shortened.
    localparam logic [3:0] EDGES_RESET    = 4'd1;
    localparam logic [3:0] EDGES_SET_ADDR = 4'd4;
    localparam logic [3:0] EDGES_INC_ADDR = 4'd1;
    localparam logic [3:0] EDGES_SET_DATA = 4'd3;
    localparam logic [3:0] EDGES_GET_DATA = 4'd9;
    localparam logic [3:0] EDGES_SET_MODE = 4'd1;
    localparam logic [3:0] EDGES_NOP      = 4'd1;

    // Read edges 1..8 each carry one data bit, LSB first.
    localparam logic [3:0] GET_FIRST_BIT = 4'd1;
    localparam logic [3:0] GET_LAST_BIT  = 4'd8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_e;

    // Edges carrying the command itself, excluding any appended increment.
    function automatic logic [3:0] data_edges(cmd_e op);
        case (op)
            CMD_RESET:    return EDGES_RESET;
            CMD_SET_ADDR: return EDGES_SET_ADDR;
            CMD_INC_ADDR: return EDGES_INC_ADDR;
            CMD_SET_DATA: return EDGES_SET_DATA;
            CMD_GET_DATA: return EDGES_GET_DATA;
            CMD_SET_MODE: return EDGES_SET_MODE;
            default:      return EDGES_NOP;
        endcase
    endfunction

    // Only data transfers may append an address increment.
    function automatic logic has_auto_inc(cmd_e op, logic auto_inc);
        return auto_inc && ((op == CMD_SET_DATA) || (op == CMD_GET_DATA));
    endfunction

    function automatic logic [3:0] burst_edges(cmd_e op, logic auto_inc);
        return data_edges(op) + {3'b000, has_auto_inc(op, auto_inc)};
    endfunction

    // Command driven on edge k: the trailing edge of an auto-increment burst
    // switches to INC_ADDR.
    function automatic cmd_e edge_cmd(cmd_e op, logic auto_inc, logic [3:0] k);
        if (has_auto_inc(op, auto_inc) && (k == data_edges(op))) begin
            return CMD_INC_ADDR;
        end
        return op;
    endfunction

    // Nibble driven on edge k.
    function automatic logic [3:0] edge_nibble(cmd_e op, logic [3:0] k,
                                               logic [15:0] addr, logic [7:0] data);
        case (op)
            CMD_SET_ADDR: begin
                case (k)
                    4'd0:    return addr[3:0];
                    4'd1:    return addr[7:4];
                    4'd2:    return addr[11:8];
                    4'd3:    return addr[15:12];
                    default: return 4'h0;
                endcase
            end
            CMD_SET_DATA: begin
                // The third edge carries 0 and releases the write strobe.
                case (k)
                    4'd0:    return data[3:0];
                    4'd1:    return data[7:4];
                    default: return 4'h0;
                endcase
            end
            CMD_SET_MODE: return {3'b000, data[0]};
            default:      return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/romemu_link_timer.sv
// Link-clock half-period timer: counts CLK_HALF system cycles per phase and
// flags the last cycle of each phase. Reloads itself so LOW and HIGH phases
// follow back to back once a burst has been started.
module romemu_link_timer #(
    parameter int CLK_HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic phase_end
);

    localparam int CW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_HALF - 1);

    logic [CW-1:0] cnt;

    // Down-counter: restart on burst start, wrap at the end of every phase.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/romemu_host_link.sv
// Host-side initiator for the ROM emulator's nibble-serial command link.
// Turns byte-level host requests into fixed-length bursts of link edges and
// shifts read data back in serially.
module romemu_host_link
    import romemu_pkg::*;
#(
    parameter int CLK_HALF = 4
) (
    input  logic        i_Clk,
    input  logic        i_nReset,
    input  logic        i_ReqValid,
    output logic        o_ReqReady,
    input  logic [2:0]  i_ReqOp,
    input  logic        i_ReqAutoInc,
    input  logic [15:0] i_ReqAddr,
    input  logic [7:0]  i_ReqData,
    output logic        o_RspValid,
    output logic [7:0]  o_RspData,
    output logic        o_TargetMode,
    output logic [2:0]  o_HCmd,
    output logic        o_HClk,
    output logic [3:0]  o_HData,
    input  logic        i_HData
);

    state_e      state, state_next;

    cmd_e        op_q;
    logic        auto_inc_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;

    cmd_e        cur_op;
    logic        cur_auto;
    logic [15:0] cur_addr;
    logic [7:0]  cur_data;

    logic [3:0]  edge_k, k_next;
    logic        burst_start, edge_end, phase_end;

    logic        hdata_meta, hdata_sync;
    logic [7:0]  shift_q;

    romemu_link_timer #(.CLK_HALF(CLK_HALF)) u_timer (
        .clk       (i_Clk),
        .rst_n     (i_nReset),
        .load      (burst_start),
        .phase_end (phase_end)
    );

    // Burst source: the self-issued reset in INIT, the live request in IDLE,
    // the latched request while a burst runs.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        cur_op   = op_q;
        cur_auto = auto_inc_q;
        cur_addr = addr_q;
        cur_data = data_q;
        if (state == ST_INIT) begin
            cur_op   = CMD_RESET;
            cur_auto = 1'b0;
            cur_addr = '0;
            cur_data = '0;
        end else if (state == ST_IDLE) begin
            cur_op   = (i_ReqOp > 3'd6) ? CMD_NOP : cmd_e'(i_ReqOp);
            cur_auto = i_ReqAutoInc;
            cur_addr = i_ReqAddr;
            cur_data = i_ReqData;
        end
    end

    // Next-state logic and burst strobes.
    always_comb begin
        state_next  = state;
        burst_start = 1'b0;
        edge_end    = 1'b0;
        case (state)
            ST_INIT: begin
                burst_start = 1'b1;
                state_next  = ST_LOW;
            end
            ST_IDLE: begin
                if (i_ReqValid) begin
                    burst_start = 1'b1;
                    state_next  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    edge_end   = 1'b1;
                    state_next = (edge_k == burst_edges(op_q, auto_inc_q) - 4'd1)
                                 ? ST_DONE : ST_LOW;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign k_next = burst_start ? 4'd0 : (edge_end ? edge_k + 4'd1 : edge_k);

    // State register; any reset restarts with the realigning RESET burst.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request and track the edge index within the burst.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            op_q       <= CMD_NOP;
            auto_inc_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            edge_k     <= '0;
        end else begin
            if (burst_start) begin
                op_q       <= cur_op;
                auto_inc_q <= cur_auto;
                addr_q     <= cur_addr;
                data_q     <= cur_data;
            end
            edge_k <= k_next;
        end
    end

    // Link pins are registered; cmd and nibble change only on entry to LOW,
    // giving a full half period of setup and hold around the rising edge.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            o_HCmd  <= CMD_NOP;
            o_HClk  <= 1'b0;
            o_HData <= '0;
        end else begin
            o_HClk <= (state_next == ST_HIGH);
            if ((state_next == ST_LOW) && (state != ST_LOW)) begin
                o_HCmd  <= edge_cmd(cur_op, cur_auto, k_next);
                o_HData <= edge_nibble(cur_op, k_next, cur_addr, cur_data);
            end else if (state_next == ST_DONE) begin
                o_HCmd <= CMD_NOP;
            end
        end
    end

    // Target mode mirrors the last SET_MODE sent; any RESET burst clears it.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            o_TargetMode <= 1'b0;
        end else if (burst_start) begin
            if (cur_op == CMD_SET_MODE) begin
                o_TargetMode <= cur_data[0];
            end else if (cur_op == CMD_RESET) begin
                o_TargetMode <= 1'b0;
            end
        end
    end

    // Read-back: synchronize the serial bit, sample it on the last HIGH cycle
    // of read edges 1..8 and publish the byte after the eighth bit.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            hdata_meta <= 1'b0;
            hdata_sync <= 1'b0;
            shift_q    <= '0;
            o_RspData  <= '0;
        end else begin
            hdata_meta <= i_HData;
            hdata_sync <= hdata_meta;
            if (edge_end && (op_q == CMD_GET_DATA) &&
                (edge_k >= GET_FIRST_BIT) && (edge_k <= GET_LAST_BIT)) begin
                shift_q <= {hdata_sync, shift_q[7:1]};
                if (edge_k == GET_LAST_BIT) begin
                    o_RspData <= {hdata_sync, shift_q[7:1]};
                end
            end
        end
    end

    assign o_ReqReady = (state == ST_IDLE);
    assign o_RspValid = (state == ST_DONE) && (op_q == CMD_GET_DATA);

endmodule
